// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor: counter encoding,
// PC width and the saturating counter update rule.
package bp_pkg;

  localparam int PC_W = 16;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } counter_t;

  // Two-bit saturating step: taken moves toward STRONG_T, not-taken toward STRONG_NT.
  function automatic counter_t sat_next(input counter_t cur, input logic taken);
    counter_t nxt;
    nxt = cur;
    unique case (cur)
      STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
      default:   nxt = STRONG_NT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/bp_table.sv
// BHT counters plus BTB valid/target (and tag when BP_TAG_CHECK_EN is defined).
// Two combinational read ports (lookup, update index) and one synchronous write port.
module bp_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 8,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IDX_W-1:0]       lookup_idx,
  output counter_t               lookup_ctr,
  output logic                   lookup_valid,
  output logic [PC_W-1:0]        lookup_target,
`ifdef BP_TAG_CHECK_EN
  output logic [PC_W-IDX_W-2:0]  lookup_tag,
  input  logic [PC_W-IDX_W-2:0]  btb_tag,
`endif
  input  logic [IDX_W-1:0]       upd_idx,
  output counter_t               upd_ctr,
  input  logic                   ctr_wen,
  input  counter_t               ctr_wdata,
  input  logic                   btb_wen,
  input  logic [PC_W-1:0]        btb_target
);

  counter_t        ctr_mem    [ENTRIES];
  logic            valid_mem  [ENTRIES];
  logic [PC_W-1:0] target_mem [ENTRIES];
`ifdef BP_TAG_CHECK_EN
  logic [PC_W-IDX_W-2:0] tag_mem [ENTRIES];
`endif

  assign lookup_ctr    = ctr_mem[lookup_idx];
  assign lookup_valid  = valid_mem[lookup_idx];
  assign lookup_target = target_mem[lookup_idx];
  assign upd_ctr       = ctr_mem[upd_idx];
`ifdef BP_TAG_CHECK_EN
  assign lookup_tag    = tag_mem[lookup_idx];
`endif

  // Every entry is cleared on reset, so the tables live in flops rather than RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_mem[i]    <= STRONG_NT;
        valid_mem[i]  <= 1'b0;
        target_mem[i] <= '0;
`ifdef BP_TAG_CHECK_EN
        tag_mem[i]    <= '0;
`endif
      end
    end else begin
      if (ctr_wen) begin
        ctr_mem[upd_idx] <= ctr_wdata;
      end
      if (btb_wen) begin
        valid_mem[upd_idx]  <= 1'b1;
        target_mem[upd_idx] <= btb_target;
`ifdef BP_TAG_CHECK_EN
        tag_mem[upd_idx]    <= btb_tag;
`endif
      end
    end
  end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage branch predictor: 2-bit BHT plus BTB, trained from decode.
// Define BP_TAG_CHECK_EN to store BTB tags and reject aliased PCs.
module dynamic_branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] PC_curr,
  input  logic [PC_W-1:0] IF_ID_PC_curr,
  input  logic            wen_BHT,
  input  logic            wen_BTB,
  input  logic            actual_taken,
  input  logic [PC_W-1:0] actual_target,
  output logic [1:0]      prediction,
  output logic            predicted_taken,
  output logic [PC_W-1:0] predicted_target
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] upd_idx;
  counter_t         lookup_ctr;
  counter_t         upd_ctr;
  counter_t         ctr_wdata;
  logic             lookup_valid;
  logic [PC_W-1:0]  lookup_target;
  logic             tag_hit;
  logic             unused_bits;

  // Bit 0 is always zero for halfword-aligned instructions.
  assign lookup_idx = PC_curr[IDX_W:1];
  assign upd_idx    = IF_ID_PC_curr[IDX_W:1];

  // Train from the stored counter so consecutive updates to one index compound.
  assign ctr_wdata = sat_next(upd_ctr, actual_taken);

`ifdef BP_TAG_CHECK_EN
  logic [PC_W-IDX_W-2:0] lookup_tag;
  logic [PC_W-IDX_W-2:0] cur_tag;
  logic [PC_W-IDX_W-2:0] upd_tag;

  assign cur_tag     = PC_curr[PC_W-1:IDX_W+1];
  assign upd_tag     = IF_ID_PC_curr[PC_W-1:IDX_W+1];
  assign tag_hit     = (lookup_tag == cur_tag);
  assign unused_bits = ^{PC_curr[0], IF_ID_PC_curr[0]};
`else
  assign tag_hit     = 1'b1;
  assign unused_bits = ^{PC_curr[0], IF_ID_PC_curr[0],
                         PC_curr[PC_W-1:IDX_W+1], IF_ID_PC_curr[PC_W-1:IDX_W+1]};
`endif

  bp_table #(
    .ENTRIES(ENTRIES)
  ) u_table (
    .clk          (clk),
    .rst          (rst),
    .lookup_idx   (lookup_idx),
    .lookup_ctr   (lookup_ctr),
    .lookup_valid (lookup_valid),
    .lookup_target(lookup_target),
`ifdef BP_TAG_CHECK_EN
    .lookup_tag   (lookup_tag),
    .btb_tag      (upd_tag),
`endif
    .upd_idx      (upd_idx),
    .upd_ctr      (upd_ctr),
    .ctr_wen      (wen_BHT),
    .ctr_wdata    (ctr_wdata),
    .btb_wen      (wen_BTB),
    .btb_target   (actual_target)
  );

  assign prediction       = lookup_ctr;
  assign predicted_target = lookup_target;
  assign predicted_taken  = lookup_ctr[1] & lookup_valid & tag_hit;

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Scoreboard bench for dynamic_branch_predictor: stimulus pushes expectations,
// a negedge monitor pops and compares while a check strobe is raised.
module tb_dynamic_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] PC_curr;
  logic [15:0] IF_ID_PC_curr;
  logic        wen_BHT;
  logic        wen_BTB;
  logic        actual_taken;
  logic [15:0] actual_target;
  logic [1:0]  prediction;
  logic        predicted_taken;
  logic [15:0] predicted_target;

  always #5 clk = ~clk;

  dynamic_branch_predictor #(.ENTRIES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .PC_curr         (PC_curr),
    .IF_ID_PC_curr   (IF_ID_PC_curr),
    .wen_BHT         (wen_BHT),
    .wen_BTB         (wen_BTB),
    .actual_taken    (actual_taken),
    .actual_target   (actual_target),
    .prediction      (prediction),
    .predicted_taken (predicted_taken),
    .predicted_target(predicted_target)
  );

  typedef struct {
    logic [1:0]  pred;
    logic        taken;
    logic [15:0] tgt;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic chk = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
    chk = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [1:0] p, input logic t,
                            input logic [15:0] tgt);
    exp_t e;
    e.pred  = p;
    e.taken = t;
    e.tgt   = tgt;
    e.name  = name;
    sb.push_back(e);
    chk = 1'b1;
  endtask

  task automatic update(input logic [15:0] pc, input logic bht, input logic btb,
                        input logic taken, input logic [15:0] tgt);
    IF_ID_PC_curr = pc;
    wen_BHT       = bht;
    wen_BTB       = btb;
    actual_taken  = taken;
    actual_target = tgt;
  endtask

  task automatic idle();
    wen_BHT = 1'b0;
    wen_BTB = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: output presented with no expectation queued");
      end else begin
        mon_e = sb.pop_front();
        if (prediction !== mon_e.pred || predicted_taken !== mon_e.taken ||
            predicted_target !== mon_e.tgt) begin
          errors++;
          $display("FAIL %s: got pred=%b taken=%b target=%h, expected pred=%b taken=%b target=%h",
                   mon_e.name, prediction, predicted_taken, predicted_target,
                   mon_e.pred, mon_e.taken, mon_e.tgt);
        end else begin
          $display("ok   %s: PC=%h pred=%b taken=%b target=%h",
                   mon_e.name, PC_curr, prediction, predicted_taken, predicted_target);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    PC_curr = 16'h0000;
    IF_ID_PC_curr = 16'h0000;
    wen_BHT = 1'b0;
    wen_BTB = 1'b0;
    actual_taken = 1'b0;
    actual_target = 16'h0000;
    step();
    step();

    // Reset state
    rst = 1'b0;
    PC_curr = 16'h0004;
    expect_out("reset", 2'b00, 1'b0, 16'h0000);
    step();

    // Training: two taken updates at 0010 -> weak-T with target 0040
    update(16'h0010, 1'b1, 1'b1, 1'b1, 16'h0040);
    PC_curr = 16'h0010;
    expect_out("train_pre", 2'b00, 1'b0, 16'h0000);
    step();
    expect_out("train_1", 2'b01, 1'b0, 16'h0040);
    step();
    idle();
    expect_out("train_2", 2'b10, 1'b1, 16'h0040);
    step();

    // Saturation high, hysteresis, saturation low
    update(16'h0010, 1'b1, 1'b0, 1'b1, 16'h0000);
    repeat (4) step();
    idle();
    expect_out("sat_hi", 2'b11, 1'b1, 16'h0040);
    step();
    update(16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    idle();
    expect_out("hyst_1", 2'b10, 1'b1, 16'h0040);
    step();
    update(16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    idle();
    expect_out("hyst_2", 2'b01, 1'b0, 16'h0040);
    step();
    update(16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (3) step();
    idle();
    expect_out("sat_lo", 2'b00, 1'b0, 16'h0040);
    step();

    // Same-cycle collision: counter 01, taken update while looking up the same PC
    update(16'h0010, 1'b1, 1'b0, 1'b1, 16'h0000);
    step();
    expect_out("collide_same", 2'b01, 1'b0, 16'h0040);
    step();
    idle();
    expect_out("collide_next", 2'b10, 1'b1, 16'h0040);
    step();

    // Aliasing: 0010 to strong-T, then look up 0020 (same index, different tag)
    update(16'h0010, 1'b1, 1'b0, 1'b1, 16'h0000);
    step();
    idle();
    expect_out("alias_own", 2'b11, 1'b1, 16'h0040);
    step();
    PC_curr = 16'h0020;
`ifdef BP_TAG_CHECK_EN
    expect_out("alias_other", 2'b11, 1'b0, 16'h0040);
`else
    expect_out("alias_other", 2'b11, 1'b1, 16'h0040);
`endif
    step();

    // BTB write with actual_taken = 0 still installs the entry
    update(16'h0006, 1'b0, 1'b1, 1'b0, 16'h1234);
    PC_curr = 16'h0006;
    expect_out("btb_nt_pre", 2'b00, 1'b0, 16'h0000);
    step();
    idle();
    expect_out("btb_nt", 2'b00, 1'b0, 16'h1234);
    step();

    // Reset mid-operation with a concurrent update that must be discarded
    rst = 1'b1;
    update(16'h0010, 1'b1, 1'b1, 1'b1, 16'h0080);
    step();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 8; i++) begin
      PC_curr = 16'(i * 2);
      expect_out($sformatf("post_rst_idx%0d", i), 2'b00, 1'b0, 16'h0000);
      step();
    end

    repeat (2) step();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
